// File: rtl/parking_pkg.sv
// Shared definitions for the parking-entry gate controller.
// Holds the one-hot state encoding and the state-vector width so the gate controller
// and anything that decodes its state agree on a single encoding.
package parking_pkg;

  localparam int unsigned STATE_W = 7;

  // One-hot encoding; any other pattern is treated as illegal and recovers to ST_IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 7'b000_0001,
    ST_WAIT_PIN  = 7'b000_0010,
    ST_BAD_PIN   = 7'b000_0100,
    ST_PIN_ALARM = 7'b000_1000,
    ST_ENTERING  = 7'b001_0000,
    ST_BLOCKED   = 7'b010_0000,
    ST_CLOSING   = 7'b100_0000
  } state_e;

endpackage

// File: rtl/occ_counter.sv
// Saturating up/down occupancy counter.
// Ports:
//   clock  - clock, all logic on posedge
//   reset  - synchronous active-high reset
//   inc    - count one car in (saturates at MAX)
//   dec    - count one car out (saturates at 0)
//   count  - current count
//   full   - registered (count == MAX), lags count by one cycle
module occ_counter #(
  parameter int unsigned MAX = 32,
  localparam int unsigned W  = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full
);

  localparam logic [W-1:0] MAX_VAL = W'(MAX);

  logic [W-1:0] count_d, count_q;
  logic         full_q;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != MAX_VAL)) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_q == MAX_VAL);
    end
  end

  assign count = count_q;
  assign full  = full_q;

endmodule

// File: rtl/parking_gate_ctrl_p.sv
// Parking-entry gate controller: validates a PIN per arriving car, drives the gate,
// raises PIN-abuse and gate-blocking alarms, and tracks lot occupancy.
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   pin, pin_valid      - keypad PIN and its 1-cycle strobe
//   pin_ref             - programmed correct PIN
//   senr_e, senr_x      - car at entry / car past the gate
//   car_exit            - 1-cycle strobe, a car left the lot
//   gate_o, gate_cls    - open gate / close-gate pulse
//   alm_pin, alm_blkg   - PIN alarm / gate-blocking alarm
//   lot_full, occupancy - lot full flag and current car count
module parking_gate_ctrl_p
  import parking_pkg::*;
#(
  parameter int unsigned PIN_W       = 8,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned CAPACITY    = 32,
  localparam int unsigned OCC_W      = $clog2(CAPACITY + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin_ref,
  input  logic             senr_e,
  input  logic             senr_x,
  input  logic             car_exit,
  output logic             gate_o,
  output logic             gate_cls,
  output logic             alm_pin,
  output logic             alm_blkg,
  output logic             lot_full,
  output logic [OCC_W-1:0] occupancy
);

  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC);
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);

  state_e             state_d, state_q;
  logic [TRIES_W-1:0] tries_d, tries_q, tries_inc;
  logic [TIMER_W-1:0] timer_d, timer_q;
  logic               good, bad, occ_inc;

  assign good      = pin_valid && (pin == pin_ref);
  assign bad       = pin_valid && (pin != pin_ref);
  assign tries_inc = (tries_q == TRIES_MAX) ? tries_q : tries_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    timer_d = '0;  // timer only survives while idling in WAIT_PIN
    case (state_q)
      ST_IDLE: begin
        if (senr_e && !lot_full) state_d = ST_WAIT_PIN;
      end
      ST_WAIT_PIN: begin
        if (good) begin
          state_d = ST_ENTERING;
        end else if (bad) begin
          state_d = ST_BAD_PIN;
          tries_d = tries_inc;
        end else if (timer_q == TIMER_MAX) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_BAD_PIN: begin
        // Reaching the limit escalates even if a good PIN arrives this cycle.
        if (tries_q == TRIES_MAX) begin
          state_d = ST_PIN_ALARM;
        end else if (good) begin
          state_d = ST_ENTERING;
        end else if (bad) begin
          tries_d = tries_inc;
        end
      end
      ST_PIN_ALARM: begin
        if (good) state_d = ST_ENTERING;
      end
      ST_ENTERING: begin
        if (senr_e && senr_x) begin
          state_d = ST_BLOCKED;
        end else if (senr_x) begin
          state_d = ST_CLOSING;
        end
      end
      ST_BLOCKED: begin
        if (good) state_d = ST_CLOSING;
      end
      ST_CLOSING: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if ((state_d == ST_ENTERING) && (state_q != ST_ENTERING)) tries_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tries_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
    end
  end

  // A car is counted in when the gate starts closing behind it.
  assign occ_inc = (state_d == ST_CLOSING) && (state_q != ST_CLOSING);

  occ_counter #(
    .MAX (CAPACITY)
  ) u_occ_counter (
    .clock (clock),
    .reset (reset),
    .inc   (occ_inc),
    .dec   (car_exit),
    .count (occupancy),
    .full  (lot_full)
  );

  assign gate_o   = (state_q == ST_ENTERING) || (state_q == ST_BLOCKED);
  assign gate_cls = (state_q == ST_CLOSING);
  assign alm_pin  = (state_q == ST_PIN_ALARM);
  assign alm_blkg = (state_q == ST_BLOCKED);

endmodule

// File: tb/tb_parking_gate_ctrl_p.sv
// Scoreboard bench for parking_gate_ctrl_p: stimulus pushes the reference model's
// expected post-edge outputs into a queue; a negedge monitor pops and compares.
module tb_parking_gate_ctrl_p;

  localparam int unsigned PIN_W = 8;
  localparam int unsigned MAXT  = 3;
  localparam int unsigned TOUT  = 8;
  localparam int unsigned CAP   = 2;
  localparam logic [7:0]  REF   = 8'h48;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pin = '0;
  logic       pin_valid = 1'b0;
  logic       senr_e = 1'b0;
  logic       senr_x = 1'b0;
  logic       car_exit = 1'b0;
  logic       gate_o, gate_cls, alm_pin, alm_blkg, lot_full;
  logic [1:0] occupancy;

  always #5 clock = ~clock;

  parking_gate_ctrl_p #(
    .PIN_W       (PIN_W),
    .MAX_TRIES   (MAXT),
    .TIMEOUT_CYC (TOUT),
    .CAPACITY    (CAP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pin       (pin),
    .pin_valid (pin_valid),
    .pin_ref   (REF),
    .senr_e    (senr_e),
    .senr_x    (senr_x),
    .car_exit  (car_exit),
    .gate_o    (gate_o),
    .gate_cls  (gate_cls),
    .alm_pin   (alm_pin),
    .alm_blkg  (alm_blkg),
    .lot_full  (lot_full),
    .occupancy (occupancy)
  );

  // {gate_o, gate_cls, alm_pin, alm_blkg, lot_full, occupancy[1:0]}
  logic [6:0] exp_q[$];
  string      tag_q[$];
  int         total = 0;
  int         bad_cnt = 0;

  // Reference model: phase of the entry procedure plus plain integer counters.
  typedef enum int {M_IDLE, M_WAIT, M_BAD, M_ALARM, M_ENTER, M_BLOCK, M_CLOSE} mode_e;
  mode_e m_mode = M_IDLE;
  int    m_tries = 0;
  int    m_wait  = 0;  // idle cycles already spent waiting for a PIN
  int    m_occ   = 0;
  bit    m_full  = 1'b0;
  string cur_tag = "reset";

  task automatic model(input bit pv, input logic [7:0] p, input bit se, input bit sx,
                       input bit ce, input bit rst);
    bit    good, badp, car_in;
    mode_e nm;
    int    nt, nw;
    if (rst) begin
      m_mode = M_IDLE; m_tries = 0; m_wait = 0; m_occ = 0; m_full = 1'b0;
      return;
    end
    good = pv && (p == REF);
    badp = pv && (p != REF);
    nm = m_mode; nt = m_tries; nw = 0; car_in = 1'b0;
    if (m_mode == M_IDLE) begin
      if (se && !m_full) nm = M_WAIT;
    end else if (m_mode == M_WAIT) begin
      if (good) nm = M_ENTER;
      else if (badp) begin nm = M_BAD; nt = (m_tries < MAXT) ? m_tries + 1 : MAXT; end
      else if (m_wait + 1 >= TOUT) nm = M_IDLE;
      else nw = m_wait + 1;
    end else if (m_mode == M_BAD) begin
      if (m_tries >= MAXT) nm = M_ALARM;
      else if (good) nm = M_ENTER;
      else if (badp) nt = (m_tries < MAXT) ? m_tries + 1 : MAXT;
    end else if (m_mode == M_ALARM) begin
      if (good) nm = M_ENTER;
    end else if (m_mode == M_ENTER) begin
      if (se && sx) nm = M_BLOCK;
      else if (sx) begin nm = M_CLOSE; car_in = 1'b1; end
    end else if (m_mode == M_BLOCK) begin
      if (good) begin nm = M_CLOSE; car_in = 1'b1; end
    end else begin
      nm = M_IDLE;
    end
    if (nm == M_ENTER) nt = 0;
    m_full = (m_occ == CAP);  // flag follows the count one cycle late
    if (car_in && !ce) m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
    else if (ce && !car_in) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
    m_mode = nm; m_tries = nt; m_wait = nw;
  endtask

  function automatic logic [6:0] expected();
    logic [1:0] o;
    o = 2'(m_occ);
    return {(m_mode == M_ENTER) || (m_mode == M_BLOCK), m_mode == M_CLOSE,
            m_mode == M_ALARM, m_mode == M_BLOCK, m_full, o};
  endfunction

  task automatic drive(input bit pv, input logic [7:0] p, input bit se, input bit sx,
                       input bit ce, input bit rst);
    pin_valid = pv; pin = p; senr_e = se; senr_x = sx; car_exit = ce; reset = rst;
    model(pv, p, se, sx, ce, rst);
    @(posedge clock);
    exp_q.push_back(expected());
    tag_q.push_back(cur_tag);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [6:0] mon_exp, mon_act;
  string      mon_tag;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {gate_o, gate_cls, alm_pin, alm_blkg, lot_full, occupancy};
      total++;
      if (mon_act !== mon_exp) begin
        bad_cnt++;
        $display("FAIL %s t=%0t got {go,cls,ap,ab,full,occ}=%b want=%b",
                 mon_tag, $time, mon_act, mon_exp);
      end
    end
  end

  initial begin
    #1;
    cur_tag = "reset";
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    cur_tag = "happy_path";
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, REF,   1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    cur_tag = "pin_alarm";
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    drive(1'b1, REF,   1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    cur_tag = "lot_full";
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    cur_tag = "timeout";
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);

    cur_tag = "blocked";
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, REF,   1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, REF,   1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    cur_tag = "inc_dec_same";
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, REF,   1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);

    cur_tag = "reset_blocked";
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, REF,   1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, REF,   1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);

    cur_tag = "random";
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] rp;
      rp = ($urandom_range(0, 1) == 1) ? REF : 8'($urandom);
      drive($urandom_range(0, 3) == 0, rp, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 199) == 0);
    end

    idle(1);
    @(posedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad_cnt++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
